// File: rtl/vector_dot_product_seq.sv
// Sequential FP32 dot product: latches A/B, folds LANES products per cycle into acc, then holds result until taken.
// Optional ReLU on the result when VECDOT_RELU_EN is defined.
module vector_dot_product_seq #(
  parameter int VLEN  = 4,
  parameter int LANES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [32*VLEN-1:0]   A,
  input  logic [32*VLEN-1:0]   B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          result,
  output logic                 busy
);

  localparam int N  = VLEN / LANES;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);
  localparam logic [31:0] QNAN = 32'h7FC00000;

  if (LANES < 1 || (VLEN % LANES) != 0) begin : g_cfg_check
    $error("vector_dot_product_seq: VLEN must be a positive multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t              state;
  logic [32*VLEN-1:0]  a_reg, b_reg;
  logic [31:0]         acc, acc_next, result_d;
  logic [CW-1:0]       beat;

  // Round-to-nearest-even multiply; denormals flush to zero, NaNs become a canonical quiet NaN.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s, grd, st;
    logic [47:0] prod;
    logic [23:0] m;
    logic [31:0] r;
    int          e;
    s    = a[31] ^ b[31];
    prod = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e    = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (prod[47]) begin
      m   = {1'b0, prod[46:24]};
      grd = prod[23];
      st  = |prod[22:0];
      e   = e + 1;
    end else begin
      m   = {1'b0, prod[45:23]};
      grd = prod[22];
      st  = |prod[21:0];
    end
    if (grd && (st || m[0])) m = m + 24'd1;
    if (m[23]) e = e + 1;
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0) ||
        (a[30:23] == 8'hFF && b[30:23] == 8'h00) || (b[30:23] == 8'hFF && a[30:23] == 8'h00))
      r = QNAN;
    else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
      r = {s, 8'hFF, 23'b0};
    else if (a[30:23] == 8'h00 || b[30:23] == 8'h00)
      r = {s, 31'b0};
    else if (e >= 255)
      r = {s, 8'hFF, 23'b0};
    else if (e <= 0)
      r = {s, 31'b0};
    else
      r = {s, 8'(e), m[22:0]};
    return r;
  endfunction

  // Round-to-nearest-even add; the smaller operand is aligned with a sticky bit jammed into the LSB.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, r;
    logic [49:0] xm, ym0, ym, sum, norm, mask;
    logic [23:0] m;
    logic        grd, st;
    int          d, p, e;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else                     begin x = b; y = a; end
    d   = int'(x[30:23]) - int'(y[30:23]);
    xm  = {1'b0, 1'b1, x[22:0], 25'b0};
    ym0 = {1'b0, 1'b1, y[22:0], 25'b0};
    if (d >= 50) begin
      ym = 50'd1;
    end else begin
      mask  = (50'd1 << d) - 50'd1;
      ym    = ym0 >> d;
      ym[0] = ym[0] | (|(ym0 & mask));
    end
    sum = (x[31] == y[31]) ? xm + ym : xm - ym;
    p = 0;
    for (int i = 0; i < 50; i++) if (sum[i]) p = i;
    e = int'(x[30:23]) + p - 48;
    if (p == 49) norm = {1'b0, sum[49:1]} | {49'b0, sum[0]};
    else         norm = sum << (48 - p);
    m   = {1'b0, norm[47:25]};
    grd = norm[24];
    st  = |norm[23:0];
    if (grd && (st || m[0])) m = m + 24'd1;
    if (m[23]) e = e + 1;
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0) ||
        (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]))
      r = QNAN;
    else if (a[30:23] == 8'hFF)
      r = a;
    else if (b[30:23] == 8'hFF)
      r = b;
    else if (a[30:23] == 8'h00 && b[30:23] == 8'h00)
      r = {a[31] & b[31], 31'b0};
    else if (a[30:23] == 8'h00)
      r = b;
    else if (b[30:23] == 8'h00)
      r = a;
    else if (sum == 50'd0)
      r = 32'h0;
    else if (e >= 255)
      r = {x[31], 8'hFF, 23'b0};
    else if (e <= 0)
      r = {x[31], 31'b0};
    else
      r = {x[31], 8'(e), m[22:0]};
    return r;
  endfunction

  // One beat of the chain: element 0 loads acc, later elements compute FPadd(p_i, acc).
  always_comb begin
    acc_next = acc;
    for (int l = 0; l < LANES; l++) begin
      int          idx;
      logic [31:0] prod;
      idx      = int'(beat) * LANES + l;
      prod     = fp_mul(a_reg[32*idx +: 32], b_reg[32*idx +: 32]);
      acc_next = (idx == 0) ? prod : fp_add(prod, acc_next);
    end
`ifdef VECDOT_RELU_EN
    result_d = acc_next[31] ? 32'h0 : acc_next;
`else
    result_d = acc_next;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      beat      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg    <= A;
          b_reg    <= B;
          beat     <= '0;
          state    <= ACCUM;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        ACCUM: begin
          acc <= acc_next;
          // The counter parks on the last beat so it never wraps.
          if (beat == LAST_BEAT) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= result_d;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          result    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
